// File: rtl/pit_request_parser.sv
`default_nettype none
// ============================================================================
// Module   : pit_request_parser
// Purpose  : Parses a byte-stream packet (type, name length, name, tail) and
//            presents a PIT lookup: a one-cycle in_bit (Interest) or out_bit
//            (Data) pulse with the first 8 name bytes and the saturated name
//            length. Malformed, truncated or aborted packets are dropped and
//            counted in a saturating 8-bit counter. After each issue the
//            parser holds pkt_ready low for GAP cycles.
// Ports    : clk, rst (sync, active-high)
//            pkt_data[7:0], pkt_valid, pkt_sop, pkt_eop -> byte stream in
//            pkt_ready                                  <- byte accept
//            prefix[63:0], len[4:0]                     <- PIT key outputs
//            in_bit, out_bit                            <- lookup pulses
//            drop_count[7:0]                            <- dropped packets
// Revision : 1.0  initial release
// ============================================================================
module pit_request_parser #(
   parameter logic [7:0]  INTEREST_TYPE = 8'h05,
   parameter logic [7:0]  DATA_TYPE     = 8'h06,
   parameter int unsigned GAP           = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  pkt_data,
   input  logic        pkt_valid,
   input  logic        pkt_sop,
   input  logic        pkt_eop,
   output logic        pkt_ready,
   output logic [63:0] prefix,
   output logic [4:0]  len,
   output logic        in_bit,
   output logic        out_bit,
   output logic [7:0]  drop_count
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LEN     = 3'd1,
      S_NAME    = 3'd2,
      S_TAIL    = 3'd3,
      S_DISCARD = 3'd4,
      S_ISSUE   = 3'd5,
      S_GAP     = 3'd6
   } state_t;

   localparam logic [3:0] C_GAP_LAST = 4'(GAP - 1);

   state_t      r_state;
   logic        r_is_data;
   logic [7:0]  r_name_len;
   logic [7:0]  r_cnt;
   logic [63:0] r_shift;
   logic [3:0]  r_gap_cnt;

   state_t      w_state_nxt;
   logic        w_is_data_nxt;
   logic [7:0]  w_name_len_nxt;
   logic [7:0]  w_cnt_nxt;
   logic [63:0] w_shift_nxt;
   logic [1:0]  w_drop_inc;
   logic [8:0]  w_drop_sum;
   logic        w_known;
   logic        w_accept;
   logic        w_issue;
   logic [2:0]  w_name_pos;
   logic [4:0]  w_len_sat;

   assign pkt_ready  = (r_state != S_ISSUE) && (r_state != S_GAP) && !rst;
   assign w_accept   = pkt_valid && pkt_ready;
   assign w_known    = (pkt_data == INTEREST_TYPE) || (pkt_data == DATA_TYPE);
   // Name byte k lands in byte lane 7-k, so the first byte is the MSB lane.
   assign w_name_pos = 3'd7 - r_cnt[2:0];
   assign w_issue    = (w_state_nxt == S_ISSUE);
   assign w_len_sat  = (r_name_len > 8'd31) ? 5'd31 : r_name_len[4:0];
   assign w_drop_sum = {1'b0, drop_count} + {7'd0, w_drop_inc};

   always_comb begin
      w_state_nxt    = r_state;
      w_is_data_nxt  = r_is_data;
      w_name_len_nxt = r_name_len;
      w_cnt_nxt      = r_cnt;
      w_shift_nxt    = r_shift;
      w_drop_inc     = 2'd0;
      case (r_state)
         S_ISSUE: w_state_nxt = S_GAP;
         S_GAP: begin
            if (r_gap_cnt == 4'd0) w_state_nxt = S_IDLE;
         end
         default: begin
            if (w_accept) begin
               if (pkt_sop) begin
                  // A sop aborts any packet in flight; DISCARD was already counted.
                  if ((r_state != S_IDLE) && (r_state != S_DISCARD)) w_drop_inc = 2'd1;
                  // The sop byte itself is then handled exactly as in IDLE.
                  w_state_nxt = S_IDLE;
                  if (w_known && !pkt_eop) begin
                     w_is_data_nxt = (pkt_data == DATA_TYPE);
                     w_state_nxt   = S_LEN;
                  end else begin
                     w_drop_inc = w_drop_inc + 2'd1;
                     if (!w_known) w_state_nxt = pkt_eop ? S_IDLE : S_DISCARD;
                  end
               end else begin
                  case (r_state)
                     S_LEN: begin
                        if ((pkt_data == 8'd0) || pkt_eop) begin
                           w_drop_inc  = 2'd1;
                           w_state_nxt = pkt_eop ? S_IDLE : S_DISCARD;
                        end else begin
                           w_name_len_nxt = pkt_data;
                           w_cnt_nxt      = 8'd0;
                           w_shift_nxt    = 64'd0;
                           w_state_nxt    = S_NAME;
                        end
                     end
                     S_NAME: begin
                        if (r_cnt[7:3] == 5'd0) w_shift_nxt[{w_name_pos, 3'b000} +: 8] = pkt_data;
                        if (r_cnt == (r_name_len - 8'd1)) begin
                           w_state_nxt = pkt_eop ? S_ISSUE : S_TAIL;
                        end else if (pkt_eop) begin
                           w_drop_inc  = 2'd1;
                           w_state_nxt = S_IDLE;
                        end else begin
                           w_cnt_nxt = r_cnt + 8'd1;
                        end
                     end
                     S_TAIL: begin
                        if (pkt_eop) w_state_nxt = S_ISSUE;
                     end
                     S_DISCARD: begin
                        if (pkt_eop) w_state_nxt = S_IDLE;
                     end
                     default: ; // IDLE without sop: orphan byte, ignored
                  endcase
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_is_data  <= 1'b0;
         r_name_len <= 8'd0;
         r_cnt      <= 8'd0;
         r_shift    <= 64'd0;
         r_gap_cnt  <= 4'd0;
         prefix     <= 64'd0;
         len        <= 5'd0;
         in_bit     <= 1'b0;
         out_bit    <= 1'b0;
         drop_count <= 8'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_is_data  <= w_is_data_nxt;
         r_name_len <= w_name_len_nxt;
         r_cnt      <= w_cnt_nxt;
         r_shift    <= w_shift_nxt;
         in_bit     <= w_issue && !w_is_data_nxt;
         out_bit    <= w_issue && w_is_data_nxt;
         // Outputs are loaded on entry to ISSUE so they are valid with the pulse.
         if (w_issue) begin
            prefix <= w_shift_nxt;
            len    <= w_len_sat;
         end
         if (r_state == S_ISSUE) begin
            r_gap_cnt <= C_GAP_LAST;
         end else if ((r_state == S_GAP) && (r_gap_cnt != 4'd0)) begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
         end
         drop_count <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pit_request_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_pit_request_parser
// Purpose  : Self-checking bench for pit_request_parser. A packet-level model
//            predicts drops, issues, prefix/len and pkt_ready; a negedge
//            process compares every DUT output against it each cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_pit_request_parser;

   localparam int GAP = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  pkt_data;
   logic        pkt_valid;
   logic        pkt_sop;
   logic        pkt_eop;
   logic        pkt_ready;
   logic [63:0] prefix;
   logic [4:0]  len;
   logic        in_bit;
   logic        out_bit;
   logic [7:0]  drop_count;

   always #5 clk = ~clk;

   pit_request_parser #(
      .INTEREST_TYPE (8'h05),
      .DATA_TYPE     (8'h06),
      .GAP           (GAP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pkt_data   (pkt_data),
      .pkt_valid  (pkt_valid),
      .pkt_sop    (pkt_sop),
      .pkt_eop    (pkt_eop),
      .pkt_ready  (pkt_ready),
      .prefix     (prefix),
      .len        (len),
      .in_bit     (in_bit),
      .out_bit    (out_bit),
      .drop_count (drop_count)
   );

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // Model state
   logic        exp_ready;
   logic        exp_in;
   logic        exp_out;
   logic [63:0] exp_prefix;
   logic [4:0]  exp_len;
   int          exp_drop;
   bit          pending_live;

   logic [7:0]  pb [0:63];
   int          pn;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("pkt_ready",  {63'd0, pkt_ready}, {63'd0, exp_ready});
         check("in_bit",     {63'd0, in_bit},    {63'd0, exp_in});
         check("out_bit",    {63'd0, out_bit},   {63'd0, exp_out});
         check("exclusive",  {63'd0, in_bit & out_bit}, 64'd0);
         check("prefix",     prefix,             exp_prefix);
         check("len",        {59'd0, len},       {59'd0, exp_len});
         check("drop_count", {56'd0, drop_count}, 64'(exp_drop));
      end
   end

   task automatic bump_drop();
      if (exp_drop < 255) exp_drop = exp_drop + 1;
   endtask

   // Sends pb[0..pn-1]; sop on the first byte if sop_first, eop on the last if eop_last.
   task automatic send(input bit sop_first, input bit eop_last, input int gap_max);
      int          drop_at;
      bit          issue;
      bit          known;
      int          nl;
      logic [63:0] npfx;
      drop_at = -1;
      issue   = 1'b0;
      nl      = 0;
      npfx    = 64'd0;
      if (sop_first) begin
         known = (pb[0] == 8'h05) || (pb[0] == 8'h06);
         if (!known) begin
            drop_at = 0;
         end else if (pn == 1) begin
            if (eop_last) drop_at = 0;
         end else begin
            nl = int'(pb[1]);
            if ((nl == 0) || (eop_last && pn == 2)) drop_at = 1;
            else if (eop_last) begin
               // Name byte k sits at index k+2; the L-th name byte is index L+1.
               if (pn - 1 < nl + 1) drop_at = pn - 1;
               else issue = 1'b1;
            end
         end
         if (issue) begin
            for (int k = 0; k < 8 && k < nl; k++) npfx[63 - 8*k -: 8] = pb[2 + k];
         end
      end
      for (int i = 0; i < pn; i++) begin
         int g;
         g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
         pkt_valid = 1'b0;
         repeat (g) begin
            @(posedge clk);
            #1;
         end
         pkt_valid = 1'b1;
         pkt_data  = pb[i];
         pkt_sop   = sop_first && (i == 0);
         pkt_eop   = eop_last && (i == pn - 1);
         @(posedge clk);
         #1;
         pkt_valid = 1'b0;
         pkt_sop   = 1'b0;
         pkt_eop   = 1'b0;
         if (sop_first && i == 0) begin
            if (pending_live) bump_drop();
            pending_live = 1'b1;
         end
         if (i == drop_at) begin
            bump_drop();
            pending_live = 1'b0;
         end
         if (eop_last && i == pn - 1) pending_live = 1'b0;
      end
      if (issue) begin
         exp_in     = (pb[0] == 8'h05);
         exp_out    = (pb[0] == 8'h06);
         exp_prefix = npfx;
         exp_len    = (nl > 31) ? 5'd31 : nl[4:0];
         exp_ready  = 1'b0;
         @(posedge clk);
         #1;
         exp_in  = 1'b0;
         exp_out = 1'b0;
         repeat (GAP) begin
            @(posedge clk);
            #1;
         end
         exp_ready = 1'b1;
      end
   endtask

   task automatic load5(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [7:0] b3, input logic [7:0] b4, input int n);
      pb[0] = b0; pb[1] = b1; pb[2] = b2; pb[3] = b3; pb[4] = b4;
      pn = n;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; pkt_data = 8'd0; pkt_valid = 1'b0; pkt_sop = 1'b0; pkt_eop = 1'b0;
      exp_ready = 1'b0; exp_in = 1'b0; exp_out = 1'b0; exp_prefix = 64'd0; exp_len = 5'd0;
      exp_drop = 0; pending_live = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_ready = 1'b1;
      @(posedge clk);
      #1;

      // Basic Interest
      load5(8'h05, 8'h03, 8'hAA, 8'hBB, 8'hCC, 5);
      send(1'b1, 1'b1, 0);
      check("lit_prefix_int", prefix, 64'hAABBCC0000000000);
      check("lit_len_int", {59'd0, len}, 64'd3);

      // Data with 10 name bytes
      pb[0] = 8'h06; pb[1] = 8'h0A;
      for (int i = 0; i < 10; i++) pb[2 + i] = 8'h11 + 8'(i);
      pn = 12;
      send(1'b1, 1'b1, 0);
      check("lit_prefix_data", prefix, 64'h1112131415161718);
      check("lit_len_data", {59'd0, len}, 64'd10);

      // Long name (40) plus 5 tail bytes: len saturates to 31
      pb[0] = 8'h06; pb[1] = 8'h28;
      for (int i = 0; i < 45; i++) pb[2 + i] = 8'h30 + 8'(i);
      pn = 47;
      send(1'b1, 1'b1, 0);
      check("lit_len_sat", {59'd0, len}, 64'd31);
      check("lit_prefix_long", prefix, 64'h3031323334353637);

      // Interest with a tail section
      pb[0] = 8'h05; pb[1] = 8'h02; pb[2] = 8'hDE; pb[3] = 8'hAD; pb[4] = 8'h00; pb[5] = 8'h01;
      pn = 6;
      send(1'b1, 1'b1, 0);

      // Drops: unknown type, zero length, truncated name
      load5(8'h07, 8'h01, 8'hAA, 8'h00, 8'h00, 3);
      send(1'b1, 1'b1, 0);
      load5(8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 2);
      send(1'b1, 1'b1, 0);
      load5(8'h05, 8'h04, 8'hAA, 8'h00, 8'h00, 3);
      send(1'b1, 1'b1, 0);
      check("lit_drop3", {56'd0, drop_count}, 64'd3);
      check("lit_prefix_kept", prefix, 64'hDEAD000000000000);
      // Known type that ends on its sop byte
      load5(8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 1);
      send(1'b1, 1'b1, 0);
      // Zero length without eop, then discarded to eop
      load5(8'h05, 8'h00, 8'h11, 8'h22, 8'h00, 4);
      send(1'b1, 1'b1, 0);

      // New sop during NAME aborts, new packet issues
      load5(8'h05, 8'h05, 8'h01, 8'h02, 8'h00, 4);
      send(1'b1, 1'b0, 0);
      load5(8'h05, 8'h03, 8'hAA, 8'hBB, 8'hCC, 5);
      send(1'b1, 1'b1, 0);
      check("lit_drop_abort", {56'd0, drop_count}, 64'd6);
      // Abort from DISCARD is not counted again
      load5(8'h07, 8'h01, 8'h00, 8'h00, 8'h00, 2);
      send(1'b1, 1'b0, 0);
      load5(8'h06, 8'h01, 8'h77, 8'h00, 8'h00, 3);
      send(1'b1, 1'b1, 0);
      // Abort whose sop byte is itself a drop: counted twice
      load5(8'h05, 8'h04, 8'hAA, 8'h00, 8'h00, 3);
      send(1'b1, 1'b0, 0);
      load5(8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 1);
      send(1'b1, 1'b1, 0);
      check("lit_drop_double", {56'd0, drop_count}, 64'd9);

      // Random valid gaps on the basic Interest
      for (int r = 0; r < 4; r++) begin
         load5(8'h05, 8'h03, 8'hAA, 8'hBB, 8'hCC, 5);
         send(1'b1, 1'b1, 3);
      end

      // Reset in mid-NAME, then remaining bytes arrive
      load5(8'h05, 8'h05, 8'h01, 8'h02, 8'h00, 4);
      send(1'b1, 1'b0, 0);
      rst = 1'b1;
      exp_ready = 1'b0;
      @(posedge clk);
      #1;
      exp_prefix = 64'd0; exp_len = 5'd0; exp_drop = 0; pending_live = 1'b0;
      rst = 1'b0;
      exp_ready = 1'b1;
      load5(8'h03, 8'h04, 8'h05, 8'h00, 8'h00, 3);
      send(1'b0, 1'b1, 0);
      check("lit_rst_prefix", prefix, 64'd0);
      check("lit_rst_drop", {56'd0, drop_count}, 64'd0);

      // Saturation: 260 single-byte unknown packets
      for (int d = 0; d < 260; d++) begin
         load5(8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 1);
         send(1'b1, 1'b1, 0);
      end
      check("lit_drop_sat", {56'd0, drop_count}, 64'd255);

      // Parser still issues after saturation
      load5(8'h06, 8'h02, 8'h5A, 8'hA5, 8'h00, 4);
      send(1'b1, 1'b1, 0);
      check("lit_prefix_final", prefix, 64'h5AA5000000000000);

      @(posedge clk);
      #1;
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
